// File: rtl/gate_stim_checker_pkg.sv
// Shared definitions for the gate stimulus checker: op encodings,
// FSM state encoding and the reference gate function.
package gate_pkg;

  // Gate function the checker expects the device under test to implement
  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_t;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of the per-vector hold counter, enough for HOLD_CYCLES up to 255
  localparam int HOLD_W = 8;

  // A full sweep has four vectors, so the mismatch count saturates here
  localparam logic [2:0] ERR_MAX = 3'd4;

  // Value a correct gate of the given function produces for operands a, b
  function automatic logic gate_expected(op_t op, logic a, logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_stim_checker_if.sv
// Signal bundle between the sweep checker and its environment: the
// request/result handshake plus the operand drive and gate response.
interface gate_stim_checker_if;

  logic       start;
  logic [1:0] op;
  logic       d1;
  logic       d2;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] vec_idx;

  // Environment side: issues requests, hosts the gate under test
  modport master (
    output start, op, gate_out,
    input  d1, d2, busy, done, pass, err_count, vec_idx
  );

  // Checker side
  modport slave (
    input  start, op, gate_out,
    output d1, d2, busy, done, pass, err_count, vec_idx
  );

endinterface

// File: rtl/gate_stim_checker_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled and
// flags the final cycle, where the gate response is sampled.
module hold_timer
  import gate_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] count;

  // Restart on every vector change (tick) and whenever no vector is applied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + HOLD_W'(1);
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/gate_stim_checker.sv
// Drives the four 2-bit input vectors to a gate under test, holds each for
// HOLD_CYCLES cycles, samples the gate once per vector and reports how many
// responses disagreed with the requested gate function.
module gate_stim_checker
  import gate_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input logic               clk,
  input logic               rst,
  gate_stim_checker_if.slave bus
);

  state_t     state;
  state_t     state_next;
  op_t        op_latched;
  logic [1:0] vec_idx;
  logic [2:0] err_count;
  logic [2:0] err_next;
  logic       pass_q;
  logic       tick;
  logic       timer_clear;
  logic       mismatch;
  logic       last_vec;
  logic       busy;
  logic       done;

  assign timer_clear = (state != APPLY);
  assign last_vec    = (vec_idx == 2'd3);

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // The gate is only judged on the last hold cycle of each vector
  assign mismatch = tick &&
                    (bus.gate_out != gate_expected(op_latched, vec_idx[1], vec_idx[0]));
  assign err_next = (mismatch && (err_count != ERR_MAX)) ? err_count + 3'd1 : err_count;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one sweep per accepted start, one DONE cycle, back to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = APPLY;
      APPLY:   if (tick && last_vec) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded purely from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      APPLY:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Sweep datapath: latch the request, step vectors, accumulate mismatches;
  // pass is computed from the count that already includes the final sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_latched <= OP_AND;
      vec_idx    <= 2'd0;
      err_count  <= 3'd0;
      pass_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_latched <= op_t'(bus.op);
            vec_idx    <= 2'd0;
            err_count  <= 3'd0;
            pass_q     <= 1'b0;
          end
        end
        APPLY: begin
          err_count <= err_next;
          if (tick) begin
            if (last_vec) begin
              pass_q <= (err_next == 3'd0);
            end else begin
              vec_idx <= vec_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.d1        = vec_idx[1];
  assign bus.d2        = vec_idx[0];
  assign bus.vec_idx   = vec_idx;
  assign bus.err_count = err_count;
  assign bus.pass      = pass_q;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: the gate under test is a 4-entry truth table
// driven from the bench, and expected results come from comparing that
// table against the truth table of the requested function.
module tb_gate_stim_checker;

  localparam int HOLD = 5;
  localparam int SWEEP = 4 * HOLD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gate_tt;
  int         checks = 0;
  int         failures = 0;

  gate_stim_checker_if bus();

  gate_stim_checker #(
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Gate under test: truth table bit k is the output for {d1,d2} == k
  assign bus.gate_out = gate_tt[{bus.d1, bus.d2}];

  // Truth table of each requested function, bit k for {d1,d2} == k
  function automatic logic [3:0] opTable(input logic [1:0] op);
    case (op)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b1110;
      2'd2:    return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  // Number of disagreeing entries among vectors 0..n-1
  function automatic int mismatchesBelow(input logic [1:0] op, input logic [3:0] tt, input int n);
    logic [3:0] diff;
    int cnt;
    diff = opTable(op) ^ tt;
    cnt = 0;
    for (int k = 0; k < n; k++) if (diff[k]) cnt++;
    return cnt;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    #1;
  endtask

  // One sweep: start, then check every cycle through DONE and two after.
  // repulseAt >= 0 re-pulses start with a different op at that cycle;
  // repulseInDone re-pulses start during the DONE cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] tt,
                               input int repulseAt, input bit repulseInDone);
    int total;
    int v;
    total = mismatchesBelow(op, tt, 4);
    gate_tt = tt;
    bus.op = op;
    bus.start = 1'b1;
    advanceCycle();
    for (int c = 0; c <= SWEEP; c++) begin
      if (c > 0) advanceCycle();
      bus.start = 1'b0;
      if (c < SWEEP) begin
        v = c / HOLD;
        checkOutput("busy", bus.busy, 1);
        checkOutput("done_early", bus.done, 0);
        checkOutput("vec_idx", bus.vec_idx, v);
        checkOutput("d1", bus.d1, (v >> 1) & 1);
        checkOutput("d2", bus.d2, v & 1);
        checkOutput("err_running", bus.err_count, mismatchesBelow(op, tt, v));
        checkOutput("pass_cleared", bus.pass, 0);
      end else begin
        checkOutput("busy_done", bus.busy, 0);
        checkOutput("done", bus.done, 1);
        checkOutput("err_final", bus.err_count, total);
        checkOutput("pass_final", bus.pass, (total == 0) ? 1 : 0);
      end
      if (c == repulseAt || (c == SWEEP && repulseInDone)) begin
        bus.start = 1'b1;
        bus.op = ~op;
      end
    end
    advanceCycle();
    bus.start = 1'b0;
    checkOutput("done_pulse", bus.done, 0);
    checkOutput("busy_idle", bus.busy, 0);
    checkOutput("pass_held", bus.pass, (total == 0) ? 1 : 0);
    checkOutput("err_held", bus.err_count, total);
    checkOutput("vec_idx_held", bus.vec_idx, 3);
    advanceCycle();
    checkOutput("no_restart", bus.busy, 0);
    checkOutput("no_done", bus.done, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'd0;
    gate_tt = 4'b1000;
    $display("[TB] reset");
    repeat (2) advanceCycle();
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_pass", bus.pass, 0);
    checkOutput("rst_err", bus.err_count, 0);
    checkOutput("rst_vec", bus.vec_idx, 0);
    rst = 1'b0;
    repeat (7) advanceCycle();

    $display("[TB] directed sweeps");
    applyStimulus(2'd0, 4'b1000, -1, 1'b0);
    applyStimulus(2'd0, 4'b0000, -1, 1'b0);
    applyStimulus(2'd2, 4'b1000, -1, 1'b0);
    applyStimulus(2'd3, 4'b1000, -1, 1'b0);

    $display("[TB] start ignored while busy and in DONE");
    applyStimulus(2'd0, 4'b1000, 7, 1'b1);
    applyStimulus(2'd1, 4'b1010, SWEEP - 1, 1'b1);

    $display("[TB] reset mid-sweep");
    gate_tt = 4'b0000;
    bus.op = 2'd3;
    bus.start = 1'b1;
    advanceCycle();
    bus.start = 1'b0;
    repeat (2 * HOLD + 2) advanceCycle();
    checkOutput("pre_rst_vec", bus.vec_idx, 2);
    checkOutput("pre_rst_err", bus.err_count, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_busy", bus.busy, 0);
    checkOutput("async_done", bus.done, 0);
    checkOutput("async_err", bus.err_count, 0);
    checkOutput("async_vec", bus.vec_idx, 0);
    checkOutput("async_d1", bus.d1, 0);
    checkOutput("async_d2", bus.d2, 0);
    checkOutput("async_pass", bus.pass, 0);
    advanceCycle();
    rst = 1'b0;
    for (int i = 0; i < SWEEP + 2; i++) begin
      advanceCycle();
      checkOutput("aborted_done", bus.done, 0);
      checkOutput("aborted_busy", bus.busy, 0);
    end
    applyStimulus(2'd0, 4'b1000, -1, 1'b0);

    $display("[TB] random sweeps");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 1) ? int'($urandom_range(0, SWEEP - 1)) : -1,
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
